aes_key_bank_switch: RTL
========================

Name: aes_key_bank_switch

Overview:
Parametrised multi-bank round-key store for the AES datapath; successor to the two-set 128-bit key switch. The expander writes half-round-keys into a shadow bank while the cipher core streams full round keys from the active bank. Supports AES-128/192/256 round counts per bank, N banks, and switching deferred to stream boundaries.

Parameters:
NUM_BANKS, 2, number of key banks (>=2)
MAX_ROUNDS, 14, largest Nr supported; each bank holds MAX_ROUNDS+1 round keys
HALF_W, 64, write-port width; round key width is 2*HALF_W

Ports:
clk  in  1  clock
kill_n  in  1  asynchronous active-low reset
wr_start  in  1  pulse: begin loading a key schedule into the write bank
wr_mode  in  2  sampled on wr_start: 0=AES-128 (Nr=10), 1=AES-192 (Nr=12), 2=AES-256 (Nr=14), 3=reserved
wr_en  in  1  half-round-key valid
wr_data  in  HALF_W  half round key
key_switch  in  1  pulse: make the most recently completed bank active
rd_start  in  1  pulse: stream all round keys of the active bank
rk_data  out  2*HALF_W  round key
rk_valid  out  1  rk_data valid
rk_round  out  4  round index of rk_data
rk_last  out  1  with rk_valid on round Nr
active_bank  out  clog2(NUM_BANKS)  bank being read
active_nr  out  4  Nr of active bank
bank_valid  out  NUM_BANKS  bank holds a complete schedule
wr_busy  out  1  load in progress
err  out  1  one-cycle pulse on any rejected request

Behaviour:
- Reset (kill_n low, async): all outputs 0, active_bank=0, wr_bank=1, no pending bank, all state machines IDLE; memory contents not cleared.
- Storage: two memories (hi, lo), depth NUM_BANKS*(MAX_ROUNDS+1), address = bank*(MAX_ROUNDS+1)+round.
- Write FSM IDLE/LOAD: wr_start in IDLE or LOAD -> LOAD, half counter h=0, bank_valid[wr_bank] cleared; pending cleared if it was wr_bank. wr_mode=3 -> err, stay/return IDLE.
- In LOAD each wr_en writes wr_data: even h -> hi (bits [2*HALF_W-1:HALF_W]), odd h -> lo, round=h>>1; h++.
- Write of h=2*(Nr+1)-1 -> bank_valid[wr_bank]=1, stored Nr latched per bank, pending=wr_bank, wr_bank advances round-robin skipping active_bank, FSM IDLE, all in the same cycle.
- wr_en in IDLE ignored, err pulse. wr_start mid-LOAD aborts, restarts same bank.
- wr_bank never equals active_bank.
- Switch: key_switch with a pending bank sets switch request; with none -> err, ignored. Request applied in first cycle read FSM is IDLE (immediately if already IDLE): active_bank<=pending, active_nr updated, pending cleared. Switch during stream takes effect the cycle after rk_last. Second key_switch while request outstanding: no effect.
- Read FSM IDLE/STREAM: rd_start in IDLE with bank_valid[active_bank]=1 -> STREAM; otherwise (busy or invalid bank) ignored with err.
- Address issued rounds 0..Nr on consecutive cycles; memory read is registered, output registered: rd_start at cycle T -> round 0 on rk_valid at T+2, round r at T+2+r, rk_last at T+2+Nr; back-to-back rd_start accepted at T+Nr+2.
- rk_data holds last value when rk_valid=0.
- Simultaneous wr_start and key_switch: switch evaluated against the pending state before wr_start clears it.
- Simultaneous load completion and key_switch: key_switch sees the new pending bank.

Test Plan:
- Reset, load AES-128 (22 halves, wr_data=h) into bank 1, key_switch, rd_start -> active_bank=1, 11 rk_valid cycles from T+2, round r = {2r, 2r+1}, rk_last at round 10, bank_valid=2'b11 after the second load.
- AES-256 load (30 halves) then AES-192 load into a 3-bank config -> active_nr 14 then 12 after each switch, rk_last at rounds 14/12, wr_bank skips active_bank.
- key_switch mid-stream of 11 rounds -> all 11 rounds come from the old bank; active_bank changes the cycle after rk_last.
- rd_start during STREAM, rd_start before any valid bank, key_switch with no pending bank, wr_en in IDLE -> each ignored with a one-cycle err.
- wr_start after 9 halves, then 22 full halves -> only the final data is read back; bank_valid was low during the reload.
- kill_n low mid-load and mid-stream -> outputs 0 immediately, active_bank=0, a later full load and read works normally.

Source files
------------

// File: rtl/aes_key_bank_switch.sv
// Multi-bank AES round-key store: the expander fills a shadow bank in halves while the active bank streams full keys.
// Stream latency: round 0 two cycles after rd_start; no backpressure, and rejected requests raise a one-cycle err.
module aes_key_bank_switch #(
    parameter int NUM_BANKS  = 2,
    parameter int MAX_ROUNDS = 14,
    parameter int HALF_W     = 64
) (
    input  logic                         clk,
    input  logic                         kill_n,
    input  logic                         wr_start,
    input  logic [1:0]                   wr_mode,
    input  logic                         wr_en,
    input  logic [HALF_W-1:0]            wr_data,
    input  logic                         key_switch,
    input  logic                         rd_start,
    output logic [2*HALF_W-1:0]          rk_data,
    output logic                         rk_valid,
    output logic [3:0]                   rk_round,
    output logic                         rk_last,
    output logic [$clog2(NUM_BANKS)-1:0] active_bank,
    output logic [3:0]                   active_nr,
    output logic [NUM_BANKS-1:0]         bank_valid,
    output logic                         wr_busy,
    output logic                         err
);
    localparam int BW    = $clog2(NUM_BANKS);
    localparam int DEPTH = NUM_BANKS * (MAX_ROUNDS + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int HW    = $clog2(2 * (MAX_ROUNDS + 1));
    localparam logic [AW-1:0] STRIDE    = AW'(MAX_ROUNDS + 1);
    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

    typedef enum logic {W_IDLE, W_LOAD}   wr_state_t;
    typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

    // Next bank after b in round-robin order, never landing on avoid.
    function automatic logic [BW-1:0] adv(input logic [BW-1:0] b, input logic [BW-1:0] avoid);
        logic [BW-1:0] n;
        n = (b == LAST_BANK) ? '0 : b + BW'(1);
        if (n == avoid) n = (n == LAST_BANK) ? '0 : n + BW'(1);
        return n;
    endfunction

    logic [HALF_W-1:0] mem_hi [DEPTH];
    logic [HALF_W-1:0] mem_lo [DEPTH];
    logic [3:0]        bank_nr [NUM_BANKS];

    wr_state_t wr_state, wr_state_n;
    rd_state_t rd_state, rd_state_n;
    logic [HW-1:0] h, h_n;
    logic [3:0]    wr_nr, wr_nr_n, cnt, cnt_n, active_nr_n;
    logic [BW-1:0] wr_bank, wr_bank_n, pend_bank, pend_bank_n, pend_eff, active_bank_n, wb_cur;
    logic          pend_vld, pend_vld_n, sw_req, sw_req_n, pend_eff_vld;
    logic          wr_ok, done, ks_ok, req, rd_go, sw_now, err_n, mem_we;
    logic [NUM_BANKS-1:0] bank_valid_n;
    logic          iss, iss_last, s1_vld, s1_last;
    logic [3:0]    iss_round, s1_round;
    logic [HALF_W-1:0] s1_hi, s1_lo;
    logic [AW-1:0] waddr, raddr;

    assign wr_busy = (wr_state == W_LOAD);

    always_comb begin
        wr_ok        = wr_start && (wr_mode != 2'd3);
        done         = (wr_state == W_LOAD) && wr_en && !wr_start && (h == HW'({wr_nr, 1'b1}));
        // A load completing this cycle is already visible to key_switch.
        pend_eff_vld = pend_vld || done;
        pend_eff     = done ? wr_bank : pend_bank;
        ks_ok        = key_switch && !sw_req && pend_eff_vld;
        req          = sw_req || ks_ok;
        rd_go        = (rd_state == R_IDLE) && rd_start && bank_valid[active_bank];
        sw_now       = req && pend_eff_vld && (rd_state == R_IDLE) && !rd_go;

        active_bank_n = sw_now ? pend_eff : active_bank;
        active_nr_n   = active_nr;
        if (sw_now) active_nr_n = done ? wr_nr : bank_nr[pend_bank];

        // The write bank steps off whichever bank becomes active.
        wb_cur    = (wr_bank == active_bank_n) ? adv(wr_bank, active_bank_n) : wr_bank;
        wr_bank_n = done ? adv(wr_bank, active_bank_n) : wb_cur;

        pend_vld_n  = pend_vld;
        pend_bank_n = pend_bank;
        if (done) begin
            pend_vld_n  = 1'b1;
            pend_bank_n = wr_bank;
        end
        if (wr_ok && pend_vld && (pend_bank == wb_cur)) pend_vld_n = 1'b0;
        if (sw_now) pend_vld_n = 1'b0;
        sw_req_n = req && !sw_now && pend_vld_n;

        bank_valid_n = bank_valid;
        if (wr_ok) bank_valid_n[wb_cur] = 1'b0;
        if (done)  bank_valid_n[wr_bank] = 1'b1;

        wr_state_n = wr_state;
        h_n        = h;
        wr_nr_n    = wr_nr;
        if (wr_start) begin
            wr_state_n = wr_ok ? W_LOAD : W_IDLE;
            h_n        = '0;
            if (wr_ok) wr_nr_n = 4'd10 + {1'b0, wr_mode, 1'b0};
        end else if ((wr_state == W_LOAD) && wr_en) begin
            h_n = h + HW'(1);
            if (done) wr_state_n = W_IDLE;
        end
        mem_we = (wr_state == W_LOAD) && wr_en && !wr_start;
        waddr  = AW'(wr_bank) * STRIDE + AW'(h[HW-1:1]);

        // Round 0 is issued in the rd_start cycle; STREAM issues 1..Nr, then idles one cycle.
        rd_state_n = rd_state;
        cnt_n      = cnt;
        iss        = 1'b0;
        iss_round  = cnt;
        if (rd_go) begin
            rd_state_n = R_STREAM;
            cnt_n      = 4'd1;
            iss        = 1'b1;
            iss_round  = 4'd0;
        end else if (rd_state == R_STREAM) begin
            if (cnt == active_nr + 4'd1) begin
                rd_state_n = R_IDLE;
            end else begin
                iss   = 1'b1;
                cnt_n = cnt + 4'd1;
            end
        end
        iss_last = (iss_round == active_nr);
        raddr    = AW'(active_bank) * STRIDE + AW'(iss_round);

        err_n = (wr_start && (wr_mode == 2'd3)) || ((wr_state == W_IDLE) && wr_en)
              || (key_switch && !sw_req && !pend_eff_vld) || (rd_start && !rd_go);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (h[0]) mem_lo[waddr] <= wr_data;
            else      mem_hi[waddr] <= wr_data;
        end
        if (iss) begin
            s1_hi <= mem_hi[raddr];
            s1_lo <= mem_lo[raddr];
        end
    end

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            wr_state    <= W_IDLE;
            rd_state    <= R_IDLE;
            h           <= '0;
            wr_nr       <= '0;
            cnt         <= '0;
            wr_bank     <= BW'(1);
            pend_bank   <= '0;
            pend_vld    <= 1'b0;
            sw_req      <= 1'b0;
            active_bank <= '0;
            active_nr   <= '0;
            bank_valid  <= '0;
            err         <= 1'b0;
            s1_vld      <= 1'b0;
            s1_round    <= '0;
            s1_last     <= 1'b0;
            rk_data     <= '0;
            rk_valid    <= 1'b0;
            rk_round    <= '0;
            rk_last     <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) bank_nr[i] <= '0;
        end else begin
            wr_state    <= wr_state_n;
            rd_state    <= rd_state_n;
            h           <= h_n;
            wr_nr       <= wr_nr_n;
            cnt         <= cnt_n;
            wr_bank     <= wr_bank_n;
            pend_bank   <= pend_bank_n;
            pend_vld    <= pend_vld_n;
            sw_req      <= sw_req_n;
            active_bank <= active_bank_n;
            active_nr   <= active_nr_n;
            bank_valid  <= bank_valid_n;
            err         <= err_n;
            if (done) bank_nr[wr_bank] <= wr_nr;
            s1_vld      <= iss;
            s1_round    <= iss_round;
            s1_last     <= iss_last;
            rk_valid    <= s1_vld;
            rk_last     <= s1_vld && s1_last;
            if (s1_vld) begin
                rk_data  <= {s1_hi, s1_lo};
                rk_round <= s1_round;
            end
        end
    end
endmodule
